// File: rtl/gamma_loader_if.sv
// Host byte stream and gamma RAM write port bundle for gamma_loader.
interface gamma_loader_if;
    logic       load_start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       en_req;
    logic       gamma_wr;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;
    logic       gamma_en;
    logic       busy;
    logic       load_done;

    modport master (
        output load_start, s_valid, s_data, en_req,
        input  s_ready, gamma_wr, gamma_wr_addr, gamma_value,
        input  gamma_en, busy, load_done
    );

    modport slave (
        input  load_start, s_valid, s_data, en_req,
        output s_ready, gamma_wr, gamma_wr_addr, gamma_value,
        output gamma_en, busy, load_done
    );
endinterface

// File: rtl/gamma_loader.sv
// Gamma curve RAM write sequencer: identity fill after reset, host curve
// loads, and gating of gamma_en until the whole curve is written.
module gamma_loader #(
    parameter int ENTRIES       = 768,
    parameter bit INIT_IDENTITY = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    gamma_loader_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD} state_t;

    localparam logic [9:0] LAST      = 10'(ENTRIES - 1);
    localparam state_t     RST_STATE = INIT_IDENTITY ? S_INIT : S_IDLE;

    state_t     r_state;
    logic [9:0] r_addr;
    logic       r_curve_ok;
    logic       r_pending;
    logic       r_wr;
    logic [9:0] r_wr_addr;
    logic [7:0] r_value;
    logic       r_en;
    logic       r_done;

    logic       w_accept;
    logic       w_last;

    assign bus.s_ready = (r_state == S_LOAD) && !bus.load_start;
    assign w_accept    = bus.s_ready && bus.s_valid;
    assign w_last      = (r_addr == LAST);

    assign bus.gamma_wr      = r_wr;
    assign bus.gamma_wr_addr = r_wr_addr;
    assign bus.gamma_value   = r_value;
    assign bus.gamma_en      = r_en;
    assign bus.load_done     = r_done;
    assign bus.busy          = (r_state != S_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= RST_STATE;
            r_addr     <= '0;
            r_curve_ok <= 1'b0;
            r_pending  <= 1'b0;
            r_wr       <= 1'b0;
            r_wr_addr  <= '0;
            r_value    <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            // Uses the registered curve_ok, so enable trails the final write.
            r_en   <= bus.en_req & r_curve_ok;
            unique case (r_state)
                S_INIT: begin
                    r_wr      <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_value   <= r_addr[7:0];
                    if (bus.load_start)
                        r_pending <= 1'b1;
                    if (w_last) begin
                        r_addr <= '0;
                        if (r_pending || bus.load_start) begin
                            r_state    <= S_LOAD;
                            r_curve_ok <= 1'b0;
                            r_pending  <= 1'b0;
                        end else begin
                            r_state    <= S_IDLE;
                            r_curve_ok <= 1'b1;
                        end
                    end else begin
                        r_addr <= r_addr + 10'd1;
                    end
                end
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state    <= S_LOAD;
                        r_addr     <= '0;
                        r_curve_ok <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (bus.load_start) begin
                        r_addr     <= '0;
                        r_curve_ok <= 1'b0;
                    end else if (w_accept) begin
                        r_wr      <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_value   <= bus.s_data;
                        if (w_last) begin
                            r_done     <= 1'b1;
                            r_curve_ok <= 1'b1;
                            r_addr     <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_addr <= r_addr + 10'd1;
                        end
                    end
                end
                default: r_state <= RST_STATE;
            endcase
        end
    end
endmodule

// File: tb/tb_gamma_loader.sv
// Randomized self-checking bench for gamma_loader against a per-address
// model of the expected RAM contents and handshake rules.
module tb_gamma_loader;
    localparam int N = 768;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
        logic       done;
        logic       gap;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    gamma_loader_if bus ();

    gamma_loader #(.ENTRIES(N), .INIT_IDENTITY(1'b1)) dut (
        .clk_sys(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_done;
    logic       rdy_pre;
    wr_t        wlog[$];
    logic [7:0] exp_d[N];

    // Called right after a falling edge: drive, let one rising edge pass,
    // then log whatever write the DUT shows afterwards.
    task automatic tick(input logic v, input logic [7:0] d,
                        input logic ls, output logic acc);
        wr_t e;
        bus.s_valid    = v;
        bus.s_data     = d;
        bus.load_start = ls;
        #1;
        rdy_pre = bus.s_ready;
        acc     = v & bus.s_ready;
        @(negedge clk);
        if (bus.gamma_wr) begin
            e.a    = bus.gamma_wr_addr;
            e.d    = bus.gamma_value;
            e.done = bus.load_done;
            e.gap  = !acc;
            wlog.push_back(e);
        end
        if (bus.load_done) n_done++;
    endtask

    task automatic stream(input int n, input int mode,
                          output int n_acc, output int en_hi);
        int   cyc;
        logic v;
        logic acc;
        n_acc = 0;
        en_hi = 0;
        cyc   = 0;
        while (n_acc < n && cyc < 8 * n + 100) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            tick(v, v ? exp_d[n_acc] : 8'($urandom), 1'b0, acc);
            if (acc) n_acc++;
            if (bus.gamma_en) en_hi++;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int   ticks;
        logic acc;
        bus.en_req     = 1'b1;
        bus.load_start = 1'b0;
        bus.s_valid    = 1'b0;
        bus.s_data     = 8'h00;
        reset_n        = 1'b0;
        #3;
        n_cmp++;
        if ({bus.gamma_wr, bus.gamma_wr_addr, bus.gamma_value, bus.gamma_en,
             bus.load_done, bus.busy, bus.s_ready} !== {1'b0, 10'd0, 8'd0,
             1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: wr=%b addr=%0d val=%0d en=%b done=%b busy=%b rdy=%b, want 0 0 0 0 0 1 0",
                     bus.gamma_wr, bus.gamma_wr_addr, bus.gamma_value,
                     bus.gamma_en, bus.load_done, bus.busy, bus.s_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        wlog.delete();
        n_done = 0;
        ticks  = 0;
        do begin
            tick(1'b0, 8'h00, 1'b0, acc);
            ticks++;
        end while (bus.busy && ticks < 1000);
        n_cmp++;
        if (ticks !== N) begin
            n_err++;
            $display("FAIL init_busy_cycles: got %0d want %0d", ticks, N);
        end
        n_cmp++;
        if (wlog.size() !== N) begin
            n_err++;
            $display("FAIL init_write_count: got %0d want %0d", wlog.size(), N);
        end
        foreach (wlog[i]) begin
            n_cmp++;
            if (wlog[i].a !== 10'(i) || wlog[i].d !== 8'(i)) begin
                n_err++;
                $display("FAIL init_entry[%0d]: got a=%0d d=%0h want a=%0d d=%0h",
                         i, wlog[i].a, wlog[i].d, i, 8'(i));
            end
        end
        n_cmp++;
        if (bus.gamma_en !== 1'b0) begin
            n_err++;
            $display("FAIL init_en_early: got %b want 0", bus.gamma_en);
        end
        tick(1'b0, 8'h00, 1'b0, acc);
        n_cmp++;
        if (bus.gamma_en !== 1'b1 || bus.gamma_wr !== 1'b0) begin
            n_err++;
            $display("FAIL init_en_rise: en=%b wr=%b want en=1 wr=0",
                     bus.gamma_en, bus.gamma_wr);
        end
    endtask

    task automatic test_load(input int mode);
        int   n_acc;
        int   en_hi;
        logic acc;
        for (int i = 0; i < N; i++)
            exp_d[i] = (mode == 2) ? 8'($urandom) : 8'((i * 3) & 255);
        wlog.delete();
        n_done = 0;
        n_cmp++;
        if (bus.gamma_en !== 1'b1) begin
            n_err++;
            $display("FAIL load%0d_en_before: got %b want 1", mode, bus.gamma_en);
        end
        tick(1'b1, 8'h11, 1'b1, acc);
        n_cmp++;
        if (rdy_pre !== 1'b0 || wlog.size() !== 0) begin
            n_err++;
            $display("FAIL load%0d_start_cycle: rdy=%b writes=%0d want 0 0",
                     mode, rdy_pre, wlog.size());
        end
        stream(N, mode, n_acc, en_hi);
        n_cmp++;
        if (n_acc !== N) begin
            n_err++;
            $display("FAIL load%0d_accepted: got %0d want %0d", mode, n_acc, N);
        end
        n_cmp++;
        if (en_hi !== 0) begin
            n_err++;
            $display("FAIL load%0d_en_during: got %0d high samples want 0",
                     mode, en_hi);
        end
        n_cmp++;
        if (wlog.size() !== N || n_done !== 1) begin
            n_err++;
            $display("FAIL load%0d_counts: writes=%0d done=%0d want %0d 1",
                     mode, wlog.size(), n_done, N);
        end
        foreach (wlog[i]) begin
            n_cmp++;
            if (i >= N || wlog[i].a !== 10'(i) || wlog[i].d !== exp_d[i % N] ||
                wlog[i].gap || wlog[i].done !== (i == N - 1)) begin
                n_err++;
                $display("FAIL load%0d_entry[%0d]: got a=%0d d=%0h done=%b gap=%b want a=%0d d=%0h",
                         mode, i, wlog[i].a, wlog[i].d, wlog[i].done,
                         wlog[i].gap, i, exp_d[i % N]);
            end
        end
        tick(1'b1, 8'hAA, 1'b0, acc);
        n_cmp++;
        if (rdy_pre !== 1'b0 || bus.gamma_en !== 1'b1 || wlog.size() !== N) begin
            n_err++;
            $display("FAIL load%0d_after: rdy=%b en=%b writes=%0d want 0 1 %0d",
                     mode, rdy_pre, bus.gamma_en, wlog.size(), N);
        end
    endtask

    task automatic test_restart();
        int   n_acc;
        int   en_hi;
        logic acc;
        for (int i = 0; i < N; i++) exp_d[i] = 8'($urandom);
        tick(1'b0, 8'h00, 1'b1, acc);
        stream(100, 0, n_acc, en_hi);
        n_cmp++;
        if (n_acc !== 100) begin
            n_err++;
            $display("FAIL restart_first_part: got %0d want 100", n_acc);
        end
        wlog.delete();
        n_done = 0;
        tick(1'b1, 8'h5A, 1'b1, acc);
        n_cmp++;
        if (rdy_pre !== 1'b0 || wlog.size() !== 0) begin
            n_err++;
            $display("FAIL restart_cycle: rdy=%b writes=%0d want 0 0",
                     rdy_pre, wlog.size());
        end
        for (int i = 0; i < N; i++) exp_d[i] = 8'($urandom);
        stream(N, 2, n_acc, en_hi);
        n_cmp++;
        if (n_acc !== N || en_hi !== 0 || wlog.size() !== N || n_done !== 1) begin
            n_err++;
            $display("FAIL restart_counts: acc=%0d en_hi=%0d writes=%0d done=%0d want %0d 0 %0d 1",
                     n_acc, en_hi, wlog.size(), n_done, N, N);
        end
        foreach (wlog[i]) begin
            n_cmp++;
            if (i >= N || wlog[i].a !== 10'(i) || wlog[i].d !== exp_d[i % N] ||
                wlog[i].gap) begin
                n_err++;
                $display("FAIL restart_entry[%0d]: got a=%0d d=%0h gap=%b want a=%0d d=%0h",
                         i, wlog[i].a, wlog[i].d, wlog[i].gap, i, exp_d[i % N]);
            end
        end
        tick(1'b0, 8'h00, 1'b0, acc);
        n_cmp++;
        if (bus.gamma_en !== 1'b1) begin
            n_err++;
            $display("FAIL restart_en_rise: got %b want 1", bus.gamma_en);
        end
    endtask

    task automatic test_init_pending();
        int   ticks;
        logic acc;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wlog.delete();
        for (int k = 0; k < 10; k++) tick(1'b0, 8'h00, 1'b0, acc);
        tick(1'b0, 8'h00, 1'b1, acc);
        ticks = 11;
        while (wlog.size() < N && ticks < 1000) begin
            tick(1'b0, 8'h00, 1'b0, acc);
            ticks++;
        end
        n_cmp++;
        if (wlog.size() !== N) begin
            n_err++;
            $display("FAIL pend_write_count: got %0d want %0d", wlog.size(), N);
        end
        foreach (wlog[i]) begin
            n_cmp++;
            if (wlog[i].a !== 10'(i) || wlog[i].d !== 8'(i)) begin
                n_err++;
                $display("FAIL pend_entry[%0d]: got a=%0d d=%0h want a=%0d d=%0h",
                         i, wlog[i].a, wlog[i].d, i, 8'(i));
            end
        end
        bus.load_start = 1'b0;
        bus.s_valid    = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pend_in_load: busy=%b rdy=%b want 1 1",
                     bus.busy, bus.s_ready);
        end
        @(negedge clk);
        tick(1'b0, 8'h00, 1'b0, acc);
        n_cmp++;
        if (bus.gamma_en !== 1'b0 || wlog.size() !== N) begin
            n_err++;
            $display("FAIL pend_curve_not_ok: en=%b writes=%0d want 0 %0d",
                     bus.gamma_en, wlog.size(), N);
        end
    endtask

    task automatic test_reset_mid_load();
        int   n_acc;
        int   en_hi;
        int   ticks;
        logic acc;
        for (int i = 0; i < N; i++) exp_d[i] = 8'($urandom);
        stream(300, 0, n_acc, en_hi);
        n_cmp++;
        if (n_acc !== 300) begin
            n_err++;
            $display("FAIL midrst_accepted: got %0d want 300", n_acc);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.gamma_wr, bus.gamma_wr_addr, bus.gamma_value, bus.gamma_en,
             bus.load_done, bus.busy, bus.s_ready} !== {1'b0, 10'd0, 8'd0,
             1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midrst_values: wr=%b addr=%0d val=%0d en=%b done=%b busy=%b rdy=%b, want 0 0 0 0 0 1 0",
                     bus.gamma_wr, bus.gamma_wr_addr, bus.gamma_value,
                     bus.gamma_en, bus.load_done, bus.busy, bus.s_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wlog.delete();
        ticks = 0;
        do begin
            tick(1'b0, 8'h00, 1'b0, acc);
            ticks++;
        end while (bus.busy && ticks < 1000);
        n_cmp++;
        if (wlog.size() !== N || ticks !== N) begin
            n_err++;
            $display("FAIL midrst_reinit: writes=%0d cycles=%0d want %0d %0d",
                     wlog.size(), ticks, N, N);
        end
        foreach (wlog[i]) begin
            n_cmp++;
            if (wlog[i].a !== 10'(i) || wlog[i].d !== 8'(i)) begin
                n_err++;
                $display("FAIL midrst_entry[%0d]: got a=%0d d=%0h want a=%0d d=%0h",
                         i, wlog[i].a, wlog[i].d, i, 8'(i));
            end
        end
        tick(1'b0, 8'h00, 1'b0, acc);
        n_cmp++;
        if (bus.gamma_en !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_en_rise: got %b want 1", bus.gamma_en);
        end
    endtask

    initial begin
        test_reset();
        test_load(0);
        test_load(1);
        test_load(2);
        test_restart();
        test_init_pending();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
